// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem between the processor (priority) and one aux requester.
// Define DMEM_ARB_STARVE_EN to add the starvation guard that forces an aux slot.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              proc_req,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [DATA_W-1:0] proc_wdata,
   input  logic              proc_wren,
   output logic              proc_stall,
   input  logic              aux_req,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   input  logic              aux_wren,
   output logic              aux_gnt,
   output logic              aux_rvalid,
   output logic [DATA_W-1:0] aux_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("dmem_port_arbiter: STARVE_LIMIT must be in 1..15");
   end

   typedef enum logic [1:0] {
      OWN_IDLE,
      OWN_PROC,
      OWN_AUX,
      OWN_FORCED
   } owner_t;

   owner_t owner;
   logic   forced;
   logic   rd_p1;
   logic   rd_p2;

`ifdef DMEM_ARB_STARVE_EN
   logic [3:0] starve_cnt;

   assign forced = aux_req && (starve_cnt == 4'(STARVE_LIMIT));

   // Clearing on the grant guarantees the processor is never stalled twice in a row.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (!aux_req || aux_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end
`else
   assign forced = 1'b0;
`endif

   always_comb begin
      if (forced)
         owner = OWN_FORCED;
      else if (proc_req)
         owner = OWN_PROC;
      else if (aux_req)
         owner = OWN_AUX;
      else
         owner = OWN_IDLE;
   end

   // Pure mux on the processor path; reset only masks the strobes.
   always_comb begin
      mem_addr   = proc_addr;
      mem_wdata  = proc_wdata;
      mem_wren   = 1'b0;
      aux_gnt    = 1'b0;
      proc_stall = 1'b0;
      case (owner)
         OWN_PROC: begin
            mem_wren = proc_wren;
         end
         OWN_AUX: begin
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            mem_wren  = aux_wren;
            aux_gnt   = 1'b1;
         end
         OWN_FORCED: begin
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            mem_wren  = aux_wren;
            aux_gnt   = 1'b1;
`ifdef DMEM_ARB_STARVE_EN
            proc_stall = proc_req;
`endif
         end
         default: begin
            mem_wren = 1'b0;
         end
      endcase
      if (!resetn) begin
         mem_wren   = 1'b0;
         aux_gnt    = 1'b0;
         proc_stall = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_p1     <= 1'b0;
         rd_p2     <= 1'b0;
         aux_rdata <= '0;
      end else begin
         rd_p1 <= aux_gnt & ~aux_wren;
         rd_p2 <= rd_p1;
         if (rd_p1)
            aux_rdata <= mem_q;
      end
   end

   assign aux_rvalid = rd_p2;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a registered-output dmem model.
// Expectations follow DMEM_ARB_STARVE_EN when it is defined for the build.
module tb_dmem_port_arbiter;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LIMIT  = 8;

   logic              clock;
   logic              resetn;
   logic              proc_req;
   logic [ADDR_W-1:0] proc_addr;
   logic [DATA_W-1:0] proc_wdata;
   logic              proc_wren;
   logic              proc_stall;
   logic              aux_req;
   logic [ADDR_W-1:0] aux_addr;
   logic [DATA_W-1:0] aux_wdata;
   logic              aux_wren;
   logic              aux_gnt;
   logic              aux_rvalid;
   logic [DATA_W-1:0] aux_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;

   logic [DATA_W-1:0] mem [0:4095];

   int n_checks = 0;
   int n_fail   = 0;

   dmem_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .proc_req   (proc_req),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_wren  (proc_wren),
      .proc_stall (proc_stall),
      .aux_req    (aux_req),
      .aux_addr   (aux_addr),
      .aux_wdata  (aux_wdata),
      .aux_wren   (aux_wren),
      .aux_gnt    (aux_gnt),
      .aux_rvalid (aux_rvalid),
      .aux_rdata  (aux_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wren   (mem_wren),
      .mem_q      (mem_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_wren)
         mem[mem_addr] <= mem_wdata;
      mem_q <= mem[mem_addr];
   end

   typedef struct {
      string             name;
      logic              preq;
      logic [ADDR_W-1:0] paddr;
      logic [DATA_W-1:0] pwd;
      logic              pwren;
      logic              areq;
      logic [ADDR_W-1:0] aaddr;
      logic [DATA_W-1:0] awd;
      logic              awren;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      logic              e_wren;
      logic              e_gnt;
      logic              e_stall;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      proc_req   = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      proc_wren  = 1'b0;
      aux_req    = 1'b0;
      aux_addr   = '0;
      aux_wdata  = '0;
      aux_wren   = 1'b0;
   endtask

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      vecs[0] = '{"idle",       1'b0, 12'h123, 32'hAAAA0001, 1'b0, 1'b0, 12'h000, 32'h0,  1'b0,
                  12'h123, 32'hAAAA0001, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"proc_wr",    1'b1, 12'h101, 32'h11,       1'b1, 1'b0, 12'h000, 32'h0,  1'b0,
                  12'h101, 32'h11,       1'b1, 1'b0, 1'b0};
      vecs[2] = '{"proc_rd",    1'b1, 12'h102, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,  1'b0,
                  12'h102, 32'h0,        1'b0, 1'b0, 1'b0};
      vecs[3] = '{"aux_wr",     1'b0, 12'h103, 32'h0,        1'b0, 1'b1, 12'h1A0, 32'h22, 1'b1,
                  12'h1A0, 32'h22,       1'b1, 1'b1, 1'b0};
      vecs[4] = '{"aux_rd",     1'b0, 12'h103, 32'h0,        1'b0, 1'b1, 12'h1A1, 32'h0,  1'b0,
                  12'h1A1, 32'h0,        1'b0, 1'b1, 1'b0};
      vecs[5] = '{"both_wr",    1'b1, 12'h104, 32'h33,       1'b1, 1'b1, 12'h1A2, 32'h44, 1'b1,
                  12'h104, 32'h33,       1'b1, 1'b0, 1'b0};
      vecs[6] = '{"both_rd",    1'b1, 12'h105, 32'h55,       1'b0, 1'b1, 12'h1A3, 32'h66, 1'b0,
                  12'h105, 32'h55,       1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 4096; i++)
         mem[i] = '0;
      mem[12'h040] = 32'hDEADBEEF;
      mem[12'h041] = 32'h12345678;
      for (int i = 0; i < 4; i++)
         mem[i] = 32'hC0DE0000 + 32'(i);

      // Reset state with every request asserted.
      resetn     = 1'b0;
      idle_inputs();
      proc_req   = 1'b1;
      proc_wren  = 1'b1;
      aux_req    = 1'b1;
      #12;
      check("rst_gnt",    32'(aux_gnt),    32'h0);
      check("rst_stall",  32'(proc_stall), 32'h0);
      check("rst_wren",   32'(mem_wren),   32'h0);
      check("rst_rvalid", 32'(aux_rvalid), 32'h0);
      check("rst_rdata",  aux_rdata,       32'h0);
      idle_inputs();
      next_cycle();
      resetn = 1'b1;

      // Combinational mux vectors, separated by idle cycles.
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         proc_req   = vecs[i].preq;
         proc_addr  = vecs[i].paddr;
         proc_wdata = vecs[i].pwd;
         proc_wren  = vecs[i].pwren;
         aux_req    = vecs[i].areq;
         aux_addr   = vecs[i].aaddr;
         aux_wdata  = vecs[i].awd;
         aux_wren   = vecs[i].awren;
         #3;
         check({vecs[i].name, "_addr"},  32'(mem_addr),   32'(vecs[i].e_addr));
         check({vecs[i].name, "_wdata"}, mem_wdata,       vecs[i].e_wdata);
         check({vecs[i].name, "_wren"},  32'(mem_wren),   32'(vecs[i].e_wren));
         check({vecs[i].name, "_gnt"},   32'(aux_gnt),    32'(vecs[i].e_gnt));
         check({vecs[i].name, "_stall"}, 32'(proc_stall), 32'(vecs[i].e_stall));
         next_cycle();
         idle_inputs();
      end
      repeat (3) next_cycle();

      // Idle aux read: grant in N, rvalid in N+2.
      aux_req  = 1'b1;
      aux_addr = 12'h040;
      #3;
      check("rd_gnt_N", 32'(aux_gnt), 32'h1);
      next_cycle();
      idle_inputs();
      #3;
      check("rd_rvalid_N1", 32'(aux_rvalid), 32'h0);
      next_cycle();
      #3;
      check("rd_rvalid_N2", 32'(aux_rvalid), 32'h1);
      check("rd_rdata_N2",  aux_rdata,       32'hDEADBEEF);
      next_cycle();
      #3;
      check("rd_rvalid_N3", 32'(aux_rvalid), 32'h0);
      check("rd_rdata_hold", aux_rdata,      32'hDEADBEEF);

      // Reset asserted the cycle after a read grant discards the read.
      next_cycle();
      aux_req  = 1'b1;
      aux_addr = 12'h041;
      #3;
      check("rstrd_gnt", 32'(aux_gnt), 32'h1);
      next_cycle();
      idle_inputs();
      resetn = 1'b0;
      next_cycle();
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #3;
         check($sformatf("rstrd_rvalid_%0d", k), 32'(aux_rvalid), 32'h0);
         check($sformatf("rstrd_rdata_%0d", k),  aux_rdata,       32'h0);
         next_cycle();
      end

      // Back-to-back reads of 0..3: rvalid contiguous two cycles behind the grants.
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            aux_req  = 1'b1;
            aux_addr = 12'(k);
         end else begin
            idle_inputs();
         end
         #3;
         check($sformatf("b2b_gnt_%0d", k),    32'(aux_gnt),    (k < 4) ? 32'h1 : 32'h0);
         check($sformatf("b2b_rvalid_%0d", k), 32'(aux_rvalid), (k >= 2 && k < 6) ? 32'h1 : 32'h0);
         if (k >= 2 && k < 6)
            check($sformatf("b2b_rdata_%0d", k), aux_rdata, 32'hC0DE0000 + 32'(k - 2));
         next_cycle();
      end

      // Withdrawn aux write under processor traffic.
      proc_req  = 1'b1;
      proc_addr = 12'h200;
      aux_req   = 1'b1;
      aux_addr  = 12'h0F0;
      aux_wdata = 32'h99;
      aux_wren  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #3;
         check($sformatf("wd_gnt_%0d", k),  32'(aux_gnt),  32'h0);
         check($sformatf("wd_wren_%0d", k), 32'(mem_wren), 32'h0);
         check($sformatf("wd_addr_%0d", k), 32'(mem_addr), 32'h200);
         next_cycle();
      end
      aux_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #3;
         check($sformatf("wd_rvalid_%0d", k), 32'(aux_rvalid), 32'h0);
         next_cycle();
      end
      check("wd_mem", mem[12'h0F0], 32'h0);

      // Contention: aux write of 5 to 0x010 against continuous processor reads.
      aux_req   = 1'b1;
      aux_addr  = 12'h010;
      aux_wdata = 32'h5;
      aux_wren  = 1'b1;
`ifdef DMEM_ARB_STARVE_EN
      for (int k = 1; k <= 10; k++) begin
         #3;
         check($sformatf("ct_gnt_%0d", k),   32'(aux_gnt),    (k == 9) ? 32'h1 : 32'h0);
         check($sformatf("ct_stall_%0d", k), 32'(proc_stall), (k == 9) ? 32'h1 : 32'h0);
         if (k == 9) begin
            check("ct_forced_addr", 32'(mem_addr), 32'h010);
            check("ct_forced_wren", 32'(mem_wren), 32'h1);
         end
         next_cycle();
      end
      aux_req = 1'b0;
      check("ct_mem", mem[12'h010], 32'h5);
`else
      for (int k = 1; k <= 12; k++) begin
         #3;
         check($sformatf("ct_gnt_%0d", k),   32'(aux_gnt),    32'h0);
         check($sformatf("ct_stall_%0d", k), 32'(proc_stall), 32'h0);
         next_cycle();
      end
      check("ct_mem_before", mem[12'h010], 32'h0);
      proc_req = 1'b0;
      #3;
      check("ct_gnt_release",  32'(aux_gnt),  32'h1);
      check("ct_wren_release", 32'(mem_wren), 32'h1);
      next_cycle();
      aux_req = 1'b0;
      check("ct_mem", mem[12'h010], 32'h5);
`endif
      idle_inputs();
      repeat (2) next_cycle();
      #3;
      check("end_rvalid", 32'(aux_rvalid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-port data memory between the processor and one auxiliary requester, such as the PS2 keyboard bridge or the VGA framebuffer fetch. The processor has priority. The auxiliary port uses a req/gnt handshake with registered read return. An optional starvation guard forces an auxiliary slot and stalls the processor for one cycle. The block sits between the processor's dmem port and `dmem`, and runs in the `clock` domain.

## Interface
- `ADDR_W`, 12: dmem word-address width.
- `DATA_W`, 32: dmem data width.
- `STARVE_LIMIT`, 8: consecutive denied aux cycles before a forced grant; legal range 1..15.
- `clock`  in  1: the single clock; all state updates on its rising edge.
- `resetn`  in  1: reset, asynchronous and active-low.
- `proc_req`  in  1: processor accesses dmem this cycle.
- `proc_addr`  in  ADDR_W: processor address.
- `proc_wdata`  in  DATA_W: processor write data.
- `proc_wren`  in  1: processor write enable; qualified by `proc_req`.
- `proc_stall`  out  1: processor access refused this cycle; the processor must hold and retry.
- `aux_req`  in  1: aux request; held until granted.
- `aux_addr`  in  ADDR_W: aux address.
- `aux_wdata`  in  DATA_W: aux write data.
- `aux_wren`  in  1: aux write enable.
- `aux_gnt`  out  1: aux access issued to dmem this cycle.
- `aux_rvalid`  out  1: one-cycle pulse; `aux_rdata` holds the read result.
- `aux_rdata`  out  DATA_W: registered aux read data; held until the next read returns.
- `mem_addr`  out  ADDR_W: to dmem address.
- `mem_wdata`  out  DATA_W: to dmem data.
- `mem_wren`  out  1: to dmem wren.
- `mem_q`  in  DATA_W: dmem q; valid the cycle after the address edge.

## Operation
- **Owner selection, combinational, each cycle, in priority order:**
  1. FORCED: `aux_req` and `starve_cnt == STARVE_LIMIT`. Only when the guard is compiled in.
  2. PROC: `proc_req`.
  3. AUX: `aux_req`.
  4. IDLE: none of the above.
- **Mux by owner:**
  - PROC: `mem_*` = `proc_*`.
  - AUX or FORCED: `mem_*` = `aux_*`, and `aux_gnt` = 1.
  - FORCED with `proc_req` = 1: `proc_stall` = 1.
  - IDLE: `mem_addr`/`mem_wdata` = `proc_addr`/`proc_wdata`, and `mem_wren` = 0.
- **`starve_cnt`** (4-bit, saturating at `STARVE_LIMIT`):
  - Increments on `aux_req & ~aux_gnt`.
  - Clears on `aux_gnt` or `~aux_req`.
- **Read return pipeline:**
  - `rd_p1` <= `aux_gnt & ~aux_wren`.
  - `rd_p2` <= `rd_p1`.
  - When `rd_p1` = 1: `aux_rdata` <= `mem_q`.
  - `aux_rvalid` = `rd_p2`.
  - Back-to-back aux reads pipeline fully, giving one `aux_rvalid` per granted read.
- **Aux handshake:**
  - Address, data and wren are stable while `aux_req` is high and `aux_gnt` is low.
  - A request is consumed on the cycle `aux_gnt` = 1.
  - Holding `aux_req` high after the grant is a new request.
  - Dropping `aux_req` before the grant withdraws the request, with no side effects.
- **Aux writes** complete at the grant edge and produce no `aux_rvalid`.

## Timing
- **Reset (`resetn` low, async):**
  - `starve_cnt`, `rd_p1`, `rd_p2` and `aux_rdata` clear to 0.
  - `aux_gnt`, `proc_stall` and `mem_wren` are 0 while in reset.
  - A read in flight is discarded; no `aux_rvalid` follows the reset release.
- **Latency:**
  - Grant is in the same cycle as the request if the processor is idle.
  - For a read granted in cycle N, `aux_rvalid` is in cycle N+2.
- **Processor path:** zero added latency; `mem_*` is a pure mux, with no register between `proc_*` and `mem_*`.
- **Simultaneous `proc_req` and `aux_req` with `starve_cnt < STARVE_LIMIT`:** the processor wins and `starve_cnt` increments.
- **Forced grant:** at most one cycle per `STARVE_LIMIT + 1` contended cycles. The counter clears on the forced grant, so the processor is never stalled twice in a row.

## Configuration
- **`DMEM_ARB_STARVE_EN` defined:**
  - The starvation counter and the FORCED owner are present.
  - `proc_stall` behaves as above.
- **`DMEM_ARB_STARVE_EN` undefined:**
  - Strict processor priority.
  - `proc_stall` is tied to 0.
  - The counter logic is removed.
  - Aux progress relies on processor idle cycles.

## Test plan
- **Reset:** assert `resetn` = 0 mid-read, at the cycle after the grant → `aux_rvalid` stays 0 after release, and `aux_rdata` = 0.
- **Idle aux read:** `proc_req` = 0, aux read of address 12'h040 holding 32'hDEADBEEF → `aux_gnt` in cycle N, `aux_rvalid` in N+2, `aux_rdata` = 32'hDEADBEEF.
- **Contention:** `proc_req` = 1 continuously, aux write of 32'h5 to 12'h010 →
  - with `_EN` and `STARVE_LIMIT` = 8: `aux_gnt` and `proc_stall` on the 9th cycle only, and dmem[12'h010] = 5;
  - without `_EN`: no grant until `proc_req` drops.
- **Back-to-back reads:** processor idle, 4 consecutive aux reads of addresses 0..3 → 4 `aux_gnt` cycles followed by 4 contiguous `aux_rvalid` pulses with data in order.
- **Processor priority:** `proc_req` and `aux_req` asserted together with `starve_cnt` = 0 → `mem_addr` = `proc_addr`, `aux_gnt` = 0, `starve_cnt` = 1.
- **Withdrawn request:** `aux_req` raised for 3 denied cycles, then dropped → `starve_cnt` returns to 0, with no dmem write and no `aux_rvalid`.
